// File: rtl/melody_sequencer.sv
// melody_sequencer
//   Steps through a writable song RAM, one note per entry, and drives the
//   musical-box tone generator with a half-period divisor and a tone enable.
//   Each note is held for (dur+1) beats, with the last GAP_CYCLES of every
//   note silent for articulation.
//
// Ports
//   clk        system clock (12 MHz), rising edge
//   rst_n      synchronous reset, active-low (song RAM is not cleared)
//   wr_en      song RAM write strobe
//   wr_addr    song RAM write address
//   wr_data    entry: [7:3] note code, [2:0] duration in beats minus 1
//   start      begin playback from entry 0 (ignored while busy)
//   stop       abort playback
//   loop_en    restart at entry 0 instead of finishing
//   tone_half  half-period divisor for the tone generator
//   tone_en    speaker enable for the tone generator
//   note_idx   index of the current entry
//   busy       high in every state except IDLE
//   done       one-cycle pulse when a non-looping song ends

module melody_sequencer #(
  parameter int CLK_HZ      = 12000000,
  parameter int BEAT_CYCLES = 1500000,
  parameter int GAP_CYCLES  = 120000,
  parameter int SONG_LEN    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  output logic [15:0] tone_half,
  output logic        tone_en,
  output logic [4:0]  note_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_NOTE, S_GAP} state_t;

  localparam logic [7:0]  END_MARK = 8'hFF;
  localparam logic [4:0]  LAST_IDX = 5'(SONG_LEN - 1);
  localparam logic [23:0] GAP_LOAD = 24'(GAP_CYCLES - 1);
  // The divisor table only holds for a 12 MHz clock; any other clock keeps
  // the speaker silent rather than playing out of tune.
  localparam bit          TABLE_OK = (CLK_HZ == 12000000);

  logic [7:0]  mem [SONG_LEN];
  logic [7:0]  rd_q;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [15:0] half_q, half_d;
  logic        en_q, en_d;
  logic [4:0]  idx_q, idx_d;
  logic        busy_q;
  logic        done_q, done_d;
  logic        end_act;

  // round(6e6 / f) for C4..B5, equal-tempered with A4 = 440 Hz
  function automatic logic [15:0] half_lut(input logic [4:0] code);
    case (code)
      5'd1:  half_lut = 16'd22934;  5'd2:  half_lut = 16'd21646;
      5'd3:  half_lut = 16'd20431;  5'd4:  half_lut = 16'd19285;
      5'd5:  half_lut = 16'd18202;  5'd6:  half_lut = 16'd17181;
      5'd7:  half_lut = 16'd16216;  5'd8:  half_lut = 16'd15306;
      5'd9:  half_lut = 16'd14447;  5'd10: half_lut = 16'd13636;
      5'd11: half_lut = 16'd12871;  5'd12: half_lut = 16'd12149;
      5'd13: half_lut = 16'd11467;  5'd14: half_lut = 16'd10823;
      5'd15: half_lut = 16'd10216;  5'd16: half_lut = 16'd9642;
      5'd17: half_lut = 16'd9101;   5'd18: half_lut = 16'd8590;
      5'd19: half_lut = 16'd8108;   5'd20: half_lut = 16'd7653;
      5'd21: half_lut = 16'd7224;   5'd22: half_lut = 16'd6818;
      5'd23: half_lut = 16'd6436;   5'd24: half_lut = 16'd6074;
      default: half_lut = 16'd0;
    endcase
  endfunction

  // NOTE occupies the whole note minus the FETCH cycle and the gap; the
  // counter runs down to zero, so it is loaded with that length minus one.
  function automatic logic [23:0] note_load(input logic [2:0] dur);
    int unsigned cyc;
    cyc = (32'(dur) + 32'd1) * 32'(BEAT_CYCLES) - 32'(GAP_CYCLES) - 32'd2;
    return cyc[23:0];
  endfunction

  // Song RAM: the read address is the index being entered, so the entry is
  // already in rd_q during FETCH; a write landing at the end of FETCH is
  // not seen until the next fetch of that address.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_q <= mem[idx_d];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 24'd0) ? cnt_q - 24'd1 : cnt_q;
    half_d  = half_q;
    en_d    = en_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    end_act = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_FETCH;
          idx_d   = 5'd0;
        end
      end
      S_FETCH: begin
        if (rd_q == END_MARK) begin
          end_act = 1'b1;
        end else begin
          state_d = S_NOTE;
          half_d  = half_lut(rd_q[7:3]);
          en_d    = TABLE_OK && (rd_q[7:3] >= 5'd1) && (rd_q[7:3] <= 5'd24);
          cnt_d   = note_load(rd_q[2:0]);
        end
      end
      S_NOTE: begin
        if (cnt_q == 24'd0) begin
          state_d = S_GAP;
          en_d    = 1'b0;
          cnt_d   = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (cnt_q == 24'd0) begin
          if (idx_q == LAST_IDX) begin
            end_act = 1'b1;
          end else begin
            state_d = S_FETCH;
            idx_d   = idx_q + 5'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (end_act) begin
      if (loop_en) begin
        state_d = S_FETCH;
        idx_d   = 5'd0;
      end else begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    // stop overrides every other transition
    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      en_d    = 1'b0;
      half_d  = 16'd0;
      idx_d   = 5'd0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 24'd0;
      half_q  <= 16'd0;
      en_q    <= 1'b0;
      idx_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      en_q    <= en_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
    end
  end

  assign tone_half = half_q;
  assign tone_en   = en_q;
  assign note_idx  = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
module tb_melody_sequencer;

  localparam int BEAT = 10;
  localparam int GAP  = 2;

  // packed observation layout: {busy, done, tone_en, note_idx[4:0], tone_half[15:0]}
  localparam logic [23:0] M_ALL = 24'hFFFFFF;
  localparam logic [23:0] M_CTL = 24'hFF0000;
  localparam logic [23:0] M_BDE = 24'hE00000;

  logic        clk = 1'b0;
  logic        rst_n, wr_en, start, stop, loop_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] tone_half;
  logic        tone_en, busy, done;
  logic [4:0]  note_idx;

  int checks = 0;
  int passed = 0;

  melody_sequencer #(
    .CLK_HZ(12000000), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SONG_LEN(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop_en(loop_en),
    .tone_half(tone_half), .tone_en(tone_en), .note_idx(note_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] obs();
    return {busy, done, tone_en, note_idx, tone_half};
  endfunction

  function automatic logic [23:0] pk(input logic b, input logic d, input logic e,
                                     input logic [4:0] idx, input logic [15:0] h);
    return {b, d, e, idx, h};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (obs() !== 24'h0) $display("FAIL reset_values: got %h want %h", obs(), 24'h0);
    else passed++;
  endtask

  // A4 one beat then marker: 1 FETCH + 7 NOTE + 2 GAP + marker FETCH, done on the next
  task automatic test_playback();
    logic [23:0] e, m;
    wr(5'd0, 8'h50);
    wr(5'd1, 8'hFF);
    go();
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) tick();
      if (k == 0)       begin e = pk(1, 0, 0, 0, 0);     m = M_CTL; end
      else if (k <= 7)  begin e = pk(1, 0, 1, 0, 13636); m = M_ALL; end
      else if (k <= 9)  begin e = pk(1, 0, 0, 0, 13636); m = M_ALL; end
      else if (k == 10) begin e = pk(1, 0, 0, 1, 0);     m = M_CTL; end
      else if (k == 11) begin e = pk(0, 1, 0, 0, 0);     m = M_BDE; end
      else              begin e = pk(0, 0, 0, 0, 0);     m = M_BDE; end
      checks++;
      if ((obs() & m) !== (e & m))
        $display("FAIL playback_k%0d: got %h want %h", k, obs() & m, e & m);
      else passed++;
    end
  endtask

  // 8'hB3 = code 22 (6818), 4 beats -> 40 cycles; 8'h01 = rest, 2 beats -> 20 cycles
  task automatic test_duration_rest();
    logic [23:0] e, m;
    wr(5'd0, 8'hB3);
    wr(5'd1, 8'h01);
    wr(5'd2, 8'hFF);
    go();
    for (int k = 0; k <= 62; k++) begin
      if (k > 0) tick();
      if (k == 0)       begin e = pk(1, 0, 0, 0, 0);    m = M_CTL; end
      else if (k <= 37) begin e = pk(1, 0, 1, 0, 6818); m = M_ALL; end
      else if (k <= 39) begin e = pk(1, 0, 0, 0, 6818); m = M_ALL; end
      else if (k == 40) begin e = pk(1, 0, 0, 1, 0);    m = M_CTL; end
      else if (k <= 59) begin e = pk(1, 0, 0, 1, 0);    m = M_ALL; end
      else if (k == 60) begin e = pk(1, 0, 0, 2, 0);    m = M_CTL; end
      else if (k == 61) begin e = pk(0, 1, 0, 0, 0);    m = M_BDE; end
      else              begin e = pk(0, 0, 0, 0, 0);    m = M_BDE; end
      checks++;
      if ((obs() & m) !== (e & m))
        $display("FAIL duration_k%0d: got %h want %h", k, obs() & m, e & m);
      else passed++;
    end
  endtask

  task automatic test_loop();
    logic [23:0] e, m;
    int p;
    wr(5'd0, 8'h50);
    wr(5'd1, 8'hFF);
    loop_en = 1'b1;
    go();
    for (int k = 1; k <= 33; k++) begin
      tick();
      p = k % 11;
      if (p == 0)       begin e = pk(1, 0, 0, 0, 0);     m = M_CTL; end
      else if (p <= 7)  begin e = pk(1, 0, 1, 0, 13636); m = M_ALL; end
      else if (p <= 9)  begin e = pk(1, 0, 0, 0, 13636); m = M_ALL; end
      else              begin e = pk(1, 0, 0, 1, 0);     m = M_CTL; end
      checks++;
      if ((obs() & m) !== (e & m))
        $display("FAIL loop_k%0d: got %h want %h", k, obs() & m, e & m);
      else passed++;
    end
    halt();
    loop_en = 1'b0;
    checks++;
    if ((obs() & M_BDE) !== 24'h0) $display("FAIL loop_stop: got %h want %h", obs() & M_BDE, 24'h0);
    else passed++;
  endtask

  // stop on the 3rd NOTE cycle of entry 1, then replay from entry 0
  task automatic test_stop();
    wr(5'd0, 8'h50);
    wr(5'd1, 8'h08);
    wr(5'd2, 8'hFF);
    go();
    repeat (13) tick();
    checks++;
    if (obs() !== pk(1, 0, 1, 1, 22934))
      $display("FAIL stop_pre: got %h want %h", obs(), pk(1, 0, 1, 1, 22934));
    else passed++;
    halt();
    checks++;
    if ((obs() & M_CTL) !== 24'h0) $display("FAIL stop_now: got %h want %h", obs() & M_CTL, 24'h0);
    else passed++;
    tick();
    checks++;
    if ((obs() & M_BDE) !== 24'h0) $display("FAIL stop_no_done: got %h want %h", obs() & M_BDE, 24'h0);
    else passed++;
    go();
    checks++;
    if ((obs() & M_CTL) !== pk(1, 0, 0, 0, 0))
      $display("FAIL replay_fetch: got %h want %h", obs() & M_CTL, pk(1, 0, 0, 0, 0));
    else passed++;
    tick();
    checks++;
    if (obs() !== pk(1, 0, 1, 0, 13636))
      $display("FAIL replay_note: got %h want %h", obs(), pk(1, 0, 1, 0, 13636));
    else passed++;
    halt();
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++;
    if ((obs() & M_CTL) !== 24'h0) $display("FAIL start_stop_idle: got %h want %h", obs() & M_CTL, 24'h0);
    else passed++;
    tick();
    checks++;
    if ((obs() & M_CTL) !== 24'h0) $display("FAIL start_stop_idle2: got %h want %h", obs() & M_CTL, 24'h0);
    else passed++;
  endtask

  // reset during entry 1; RAM (50, 08, FF from the stop test) must survive
  task automatic test_reset_mid_note();
    go();
    repeat (12) tick();
    checks++;
    if (obs() !== pk(1, 0, 1, 1, 22934))
      $display("FAIL rst_pre: got %h want %h", obs(), pk(1, 0, 1, 1, 22934));
    else passed++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (obs() !== 24'h0) $display("FAIL rst_mid_note: got %h want %h", obs(), 24'h0);
    else passed++;
    go();
    tick();
    checks++;
    if (obs() !== pk(1, 0, 1, 0, 13636))
      $display("FAIL rst_ram0: got %h want %h", obs(), pk(1, 0, 1, 0, 13636));
    else passed++;
    repeat (10) tick();
    checks++;
    if (obs() !== pk(1, 0, 1, 1, 22934))
      $display("FAIL rst_ram1: got %h want %h", obs(), pk(1, 0, 1, 1, 22934));
    else passed++;
    halt();
  endtask

  // a write to entry 0 during its FETCH is not seen by that fetch
  task automatic test_read_before_write();
    wr(5'd0, 8'h50);
    wr(5'd1, 8'hFF);
    go();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'h08;
    tick();
    wr_en = 1'b0;
    checks++;
    if (obs() !== pk(1, 0, 1, 0, 13636))
      $display("FAIL rbw_old: got %h want %h", obs(), pk(1, 0, 1, 0, 13636));
    else passed++;
    halt();
    go();
    tick();
    checks++;
    if (obs() !== pk(1, 0, 1, 0, 22934))
      $display("FAIL rbw_new: got %h want %h", obs(), pk(1, 0, 1, 0, 22934));
    else passed++;
    halt();
  endtask

  // code 24 top of table; code 25 decodes as a rest
  task automatic test_table_edges();
    wr(5'd0, 8'hC0);
    wr(5'd1, 8'hC8);
    wr(5'd2, 8'hFF);
    go();
    tick();
    checks++;
    if (obs() !== pk(1, 0, 1, 0, 6074))
      $display("FAIL code24: got %h want %h", obs(), pk(1, 0, 1, 0, 6074));
    else passed++;
    repeat (10) tick();
    checks++;
    if (obs() !== pk(1, 0, 0, 1, 0))
      $display("FAIL code25_rest: got %h want %h", obs(), pk(1, 0, 0, 1, 0));
    else passed++;
    halt();
  endtask

  // 32 one-beat C4 notes, no marker: ends after entry 31's gap
  task automatic test_wrap();
    logic [23:0] e;
    int dones;
    dones = 0;
    for (int i = 0; i < 32; i++) wr(5'(i), 8'h08);
    go();
    for (int k = 1; k <= 321; k++) begin
      tick();
      if (done && k != 320) dones++;
      if ((k % 10 == 0) && k <= 310) begin
        e = pk(1, 0, 0, 5'(k / 10), 0);
        checks++;
        if ((obs() & M_CTL) !== e)
          $display("FAIL wrap_idx_k%0d: got %h want %h", k, obs() & M_CTL, e);
        else passed++;
      end
      if (k == 311 || k == 319) begin
        e = pk(1, 0, (k == 311), 31, 22934);
        checks++;
        if (obs() !== e) $display("FAIL wrap_last_k%0d: got %h want %h", k, obs(), e);
        else passed++;
      end
      if (k >= 320) begin
        e = pk(0, (k == 320), 0, 0, 0);
        checks++;
        if ((obs() & M_BDE) !== e) $display("FAIL wrap_end_k%0d: got %h want %h", k, obs() & M_BDE, e);
        else passed++;
      end
    end
    checks++;
    if (dones !== 0) $display("FAIL wrap_stray_done: got %0d want 0", dones);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 8'h00;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    test_reset();
    test_playback();
    test_duration_rest();
    test_loop();
    test_stop();
    test_start_stop_idle();
    test_reset_mid_note();
    test_read_before_write();
    test_table_edges();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
